// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) returning quotient to LO, remainder to HI.
// Latency: WIDTH+1 cycles from accepted start to done; 1 cycle when DIV_EARLY_OUT_EN takes the early exit.
// Backpressure: stall holds the pipeline while a request is accepted or iterating; cancel aborts without writing.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic             cancel,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIV,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic             dz_q, dz_d;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             early_out;
   logic [WIDTH:0]   rem_sh;
   logic             trial_ok;
   logic [WIDTH-1:0] rem_next, quo_next;
   logic [WIDTH-1:0] rem_fix, quo_fix;
   logic             last_iter;

   // Operand magnitudes and the per-iteration trial subtraction.
   always_comb begin
      a_neg     = is_signed & opa[WIDTH-1];
      b_neg     = is_signed & opb[WIDTH-1];
      a_mag     = a_neg ? ('0 - opa) : opa;
      b_mag     = b_neg ? ('0 - opb) : opb;
      // The remainder needs one extra bit after the shift since the divisor can use all WIDTH bits.
      rem_sh    = {rem_q, quo_q[WIDTH-1]};
      trial_ok  = rem_sh >= {1'b0, dvs_q};
      rem_next  = trial_ok ? WIDTH'(rem_sh - {1'b0, dvs_q}) : rem_sh[WIDTH-1:0];
      quo_next  = {quo_q[WIDTH-2:0], trial_ok};
      quo_fix   = qneg_q ? ('0 - quo_next) : quo_next;
      rem_fix   = rneg_q ? ('0 - rem_next) : rem_next;
      last_iter = (cnt_q == CW'(WIDTH - 1));
   end

`ifdef DIV_EARLY_OUT_EN
   // Divide by zero, or a dividend smaller than the divisor, needs no iterations.
   assign early_out = (opb == '0) || (a_mag < b_mag);
`else
   assign early_out = 1'b0;
`endif

   // Next-state, datapath updates and stall.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      done_d  = 1'b0;
      lo_d    = lo_q;
      hi_d    = hi_q;
      dz_d    = dz_q;
      stall   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && !cancel) begin
               stall  = 1'b1;
               rem_d  = '0;
               quo_d  = a_mag;
               dvs_d  = b_mag;
               qneg_d = a_neg ^ b_neg;
               rneg_d = a_neg;
               cnt_d  = '0;
               if (early_out) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  lo_d    = (opb == '0) ? '1 : '0;
                  hi_d    = opa;
                  dz_d    = (opb == '0);
               end else begin
                  state_d = S_DIV;
               end
            end
         end
         S_DIV: begin
            stall = 1'b1;
            if (cancel) begin
               state_d = S_IDLE;
            end else begin
               rem_d = rem_next;
               quo_d = quo_next;
               cnt_d = cnt_q + 1'b1;
               if (last_iter) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  // With a zero divisor the remainder path already rebuilds opa; only LO needs forcing.
                  lo_d    = (dvs_q == '0) ? '1 : quo_fix;
                  hi_d    = rem_fix;
                  dz_d    = (dvs_q == '0);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
         done_q <= 1'b0;
         lo_q   <= '0;
         hi_q   <= '0;
         dz_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
         qneg_q <= qneg_d;
         rneg_q <= rneg_d;
         done_q <= done_d;
         lo_q   <= lo_d;
         hi_q   <= hi_d;
         dz_q   <= dz_d;
      end
   end

   assign done      = done_q;
   assign result_lo = lo_q;
   assign result_hi = hi_q;
   assign div_zero  = dz_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: vector table, reference-model random vectors, cancel and reset sequences.
// Latency expectation follows DIV_EARLY_OUT_EN the same way the design build does.
// Inputs driven 1ns after the rising edge; outputs sampled there too.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, is_signed, cancel;
   logic [31:0] opa, opb;
   logic        stall, done, div_zero;
   logic [31:0] result_lo, result_hi;

   int checks = 0;
   int errors = 0;

   logic [31:0] last_lo = '0, last_hi = '0;
   logic        last_dz = 1'b0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sgn;
      logic [31:0] lo;
      logic [31:0] hi;
      logic        dz;
      int          lat;
   } exp_t;

   exp_t sb[$];

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sgn;
      logic [31:0] lo;
      logic [31:0] hi;
      logic        dz;
   } vec_t;

   vec_t vecs[12];

   always #5 clk = ~clk;

   div_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .is_signed (is_signed),
      .cancel    (cancel),
      .opa       (opa),
      .opb       (opb),
      .stall     (stall),
      .done      (done),
      .result_lo (result_lo),
      .result_hi (result_hi),
      .div_zero  (div_zero)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input logic sgn);
      logic [31:0] ma, mb;
      ma = (sgn && a[31]) ? -a : a;
      mb = (sgn && b[31]) ? -b : b;
`ifdef DIV_EARLY_OUT_EN
      if (b == 32'd0 || ma < mb) return 1;
`endif
      if (ma == mb) return 33;
      return 33;
   endfunction

   // Reference model built on native SV division.
   task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          output logic [31:0] lo, output logic [31:0] hi, output logic dz);
      dz = (b == 32'd0);
      if (b == 32'd0) begin
         lo = '1;
         hi = a;
      end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         lo = 32'h8000_0000;
         hi = 32'd0;
      end else if (sgn) begin
         lo = $signed(a) / $signed(b);
         hi = $signed(a) % $signed(b);
      end else begin
         lo = a / b;
         hi = a % b;
      end
   endtask

   // Issue one divide, hold start until done, then compare against the scoreboard head.
   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic [31:0] elo, input logic [31:0] ehi, input logic edz);
      exp_t e;
      int   cyc;
      logic got, stall_bad;
      e.a = a; e.b = b; e.sgn = sgn; e.lo = elo; e.hi = ehi; e.dz = edz;
      e.lat = exp_lat(a, b, sgn);
      sb.push_back(e);
      start = 1'b1; opa = a; opb = b; is_signed = sgn;
      #1;
      check("stall_cycle0", {31'd0, stall}, 32'd1);
      cyc = 0; got = 1'b0; stall_bad = 1'b0;
      while (!got && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
         // Operands only need to be stable in cycle 0.
         opa = $urandom; opb = $urandom; is_signed = $urandom_range(0, 1);
         if (done) got = 1'b1;
         else if (!stall) stall_bad = 1'b1;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=no_done expected=done_within_100_cycles");
         void'(sb.pop_front());
      end else begin
         e = sb.pop_front();
         check("latency", cyc, e.lat);
         check("result_lo", result_lo, e.lo);
         check("result_hi", result_hi, e.hi);
         check("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
         check("stall_in_done", {31'd0, stall}, 32'd0);
         check("stall_while_busy", {31'd0, stall_bad}, 32'd0);
         last_lo = e.lo; last_hi = e.hi; last_dz = e.dz;
      end
      @(posedge clk); #1;
      start = 1'b0;
      check("done_one_cycle", {31'd0, done}, 32'd0);
   endtask

   initial begin
      logic [31:0] ra, rb, rlo, rhi;
      logic        rs, rdz, seen;

      vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
      vecs[1]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
      vecs[2]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0};
      vecs[3]  = '{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1'b1};
      vecs[4]  = '{32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1};
      vecs[5]  = '{32'd3,          32'd10,         1'b0, 32'd0,          32'd3,          1'b0};
      vecs[6]  = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0};
      vecs[7]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0};
      vecs[8]  = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF,  1'b0};
      vecs[9]  = '{32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1,          1'b0};
      vecs[10] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0};
      vecs[11] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0,          1'b0};

      rst = 1'b1; start = 1'b0; is_signed = 1'b0; cancel = 1'b0; opa = '0; opb = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_lo", result_lo, 32'd0);
      check("rst_hi", result_hi, 32'd0);
      check("rst_dz", {31'd0, div_zero}, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++)
         run_div(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].lo, vecs[i].hi, vecs[i].dz);

      for (int i = 0; i < 8; i++) begin
         ra = $urandom;
         rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
         rs = 1'($urandom_range(0, 1));
         ref_div(ra, rb, rs, rlo, rhi, rdz);
         run_div(ra, rb, rs, rlo, rhi, rdz);
      end

      // start together with cancel in IDLE is not accepted.
      start = 1'b1; cancel = 1'b1; opa = 32'd50; opb = 32'd5; is_signed = 1'b0;
      #1;
      check("start_cancel_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      start = 1'b0; cancel = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done || stall) seen = 1'b1;
      end
      check("start_cancel_ignored", {31'd0, seen}, 32'd0);

      // Cancel during iteration: back to IDLE, no done, results untouched.
      start = 1'b1; opa = 32'd100; opb = 32'd7; is_signed = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0; start = 1'b0;
      check("cancel_idle_stall", {31'd0, stall}, 32'd0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) seen = 1'b1;
      end
      check("cancel_no_done", {31'd0, seen}, 32'd0);
      check("cancel_lo_kept", result_lo, last_lo);
      check("cancel_hi_kept", result_hi, last_hi);
      check("cancel_dz_kept", {31'd0, div_zero}, {31'd0, last_dz});
      run_div(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);

      // Reset in the middle of a divide clears everything immediately.
      start = 1'b1; opa = 32'd100; opb = 32'd7; is_signed = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      rst = 1'b1; start = 1'b0;
      #1;
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_lo", result_lo, 32'd0);
      check("midrst_hi", result_hi, 32'd0);
      check("midrst_dz", {31'd0, div_zero}, 32'd0);
      check("midrst_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) seen = 1'b1;
      end
      check("midrst_no_done", {31'd0, seen}, 32'd0);
      run_div(32'd3, 32'd10, 1'b0, 32'd0, 32'd3, 1'b0);

      check("scoreboard_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for the execute stage of the five-stage MIPS pipeline. It consumes the decoded DIV/DIVU request and both register operands from execute, holds the pipeline with a stall while iterating, and returns quotient and remainder for the HI/LO write path. Radix-2 restoring algorithm on operand magnitudes, with a sign fix-up for signed division.

## Interface
- `WIDTH`, default 32: operand and result width; iteration count equals `WIDTH`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset: one clock, asynchronous, active-high.
- `start`  in  1  divide requested by the instruction in execute; held high by the pipeline while stalled.
- `is_signed`  in  1  1 = DIV, 0 = DIVU; sampled with `start`.
- `cancel`  in  1  flush/exception kill of the execute-stage instruction.
- `opa`  in  WIDTH  dividend (rs); sampled on the accepting edge.
- `opb`  in  WIDTH  divisor (rt); sampled on the accepting edge.
- `stall`  out  1  combinational; holds fetch/decode/execute.
- `done`  out  1  registered; results valid this cycle.
- `result_lo`  out  WIDTH  registered quotient, destined for LO.
- `result_hi`  out  WIDTH  registered remainder, destined for HI.
- `div_zero`  out  1  registered; the last completed divide had `opb` = 0.

## Operation
- States: IDLE, DIV, DONE.
- IDLE, when `start`=1 and `cancel`=0:
  - Latch |opa|, |opb|, quotient sign = sign(opa) XOR sign(opb), remainder sign = sign(opa). Signs count only when `is_signed`=1.
  - Clear the iteration counter and go to DIV.
- DIV, one iteration per cycle:
  - Shift {rem, quo} left by 1.
  - Trial subtract the divisor magnitude from rem.
  - If the result is non-negative, keep it and set quo[0]=1.
  - After `WIDTH` iterations, apply sign fix-up, write `result_lo`/`result_hi`, and go to DONE.
- Sign fix-up: negate quo if the quotient sign is 1; negate rem if the remainder sign is 1. Two's-complement arithmetic, modulo 2^WIDTH.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: `result_lo`=0x80000000, `result_hi`=0. No trap.
- Divide by zero, either signedness: `result_lo`=all ones, `result_hi`=`opa` (original), `div_zero`=1. Otherwise `div_zero`=0 at completion.
- DONE: `done`=1 for exactly one cycle, then IDLE unconditionally. `start` is ignored in DONE, since it is still the same instruction leaving execute.
- `cancel` in DIV or DONE: next state IDLE. `done` is not asserted afterwards, and the result registers and `div_zero` are unchanged.
- `cancel` and `start` together in IDLE: the request is not accepted.
- `stall` = (IDLE & `start` & ~`cancel`) | DIV.
- `result_lo`, `result_hi` and `div_zero` hold their values until the next completion.
- Reset: state IDLE, counter 0, `done`=0, `result_lo`=0, `result_hi`=0, `div_zero`=0.
- Reset mid-operation: immediate return to these values; no partial result is written.

## Timing
- Cycle 0: `start` high in IDLE. `stall`=1; the edge at the end of cycle 0 captures the operands.
- Cycles 1..WIDTH: DIV, `stall`=1.
- Cycle WIDTH+1: DONE, `done`=1, results valid, `stall`=0; the pipeline advances at the end of this cycle.
- Full-length latency: WIDTH+1 cycles from `start` to `done` (33 cycles at the default).
- A new `start` is accepted no earlier than the cycle after DONE, so back-to-back divides repeat every WIDTH+2 cycles.
- Operands must stay stable only in cycle 0.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - In IDLE, if `opb`=0 or |opa| < |opb|, the request goes straight from IDLE to DONE with no iterations.
  - `done` rises in cycle 1.
  - Results: the divide-by-zero rule when `opb`=0; otherwise `result_lo`=0 and `result_hi`=`opa`.
- `DIV_EARLY_OUT_EN` undefined:
  - Every request takes the full WIDTH iterations.
  - Divide by zero produces the same final values through the normal path.
  - `done` rises in cycle WIDTH+1.

## Test plan
- DIVU 100 / 7 → `done` in cycle 33: `result_lo`=14, `result_hi`=2, `div_zero`=0; `stall` high in cycles 0–32.
- DIV 0xFFFFFFF9 (−7) / 2 → `result_lo`=0xFFFFFFFD (−3), `result_hi`=0xFFFFFFFF (−1).
- DIV 0x80000000 / 0xFFFFFFFF → `result_lo`=0x80000000, `result_hi`=0; no hang.
- DIVU 5 / 0 → `result_lo`=0xFFFFFFFF, `result_hi`=5, `div_zero`=1. `done` in cycle 1 with `DIV_EARLY_OUT_EN` defined, cycle 33 without.
- Start 100 / 7, then pulse `cancel` in cycle 10 → IDLE in cycle 11, no `done`, results keep previous values. Next, `start` 9/3 → `result_lo`=3, `result_hi`=0.
- Assert `rst` in cycle 15 of a divide → all outputs 0 at once. After release, DIVU 3 / 10 → `result_lo`=0, `result_hi`=3, `done` in cycle 1 with the macro defined, cycle 33 without.
